// File: rtl/overlay_compositor.sv
// Two-stage video overlay compositor: stage 1 registers the pixel and computes hit flags,
// stage 2 resolves overlay priority/blend into the registered VGA outputs.
module overlay_compositor #(
  parameter int                CW           = 10,
  parameter int                NUM_BOXES    = 2,
  parameter int                NUM_MARKS    = 2,
  parameter int                BLINK_FRAMES = 0,
  parameter logic [CW-1:0]     TRACE_BLUE   = 'h032
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    pix_valid,
  input  logic                    frame_start,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic [CW-1:0]           iRed,
  input  logic [CW-1:0]           iGreen,
  input  logic [CW-1:0]           iBlue,
  input  logic                    is_ball,
  input  logic                    SHOW_BALL,
  input  logic                    SHOW_BOX,
  input  logic                    traced,
  input  logic                    ABOVE_T,
  input  logic                    blend_mode,
  input  logic [NUM_BOXES-1:0]    box_en,
  input  logic [10*NUM_BOXES-1:0] box_tlx,
  input  logic [10*NUM_BOXES-1:0] box_tly,
  input  logic [10*NUM_BOXES-1:0] box_brx,
  input  logic [10*NUM_BOXES-1:0] box_bry,
  input  logic [10*NUM_MARKS-1:0] mark_x,
  input  logic [10*NUM_MARKS-1:0] mark_y,
  output logic [CW-1:0]           VGA_R,
  output logic [CW-1:0]           VGA_G,
  output logic [CW-1:0]           VGA_B,
  output logic                    out_valid,
  output logic [9:0]              out_x,
  output logic [9:0]              out_y
);

  localparam logic [CW-1:0] FS    = {CW{1'b1}};
  localparam logic [CW-1:0] ZERO  = '0;
  localparam int            CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // ---------------- cursor blink ----------------
  logic [CNT_W-1:0] frame_cnt_reg;
  logic             cursor_vis_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt_reg  <= '0;
      cursor_vis_reg <= 1'b1;
    end else if ((BLINK_FRAMES != 0) && frame_start) begin
      if (frame_cnt_reg == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_reg  <= '0;
        cursor_vis_reg <= ~cursor_vis_reg;
      end else begin
        frame_cnt_reg  <= frame_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------- stage 1 hit detection ----------------
  logic [NUM_MARKS-1:0] mark_hit;
  logic [NUM_BOXES-1:0] box_hit;

  generate
    for (genvar gi = 0; gi < NUM_MARKS; gi++) begin : g_mark
      assign mark_hit[gi] = (DrawX == mark_x[10*gi +: 10]) && (DrawY == mark_y[10*gi +: 10]);
    end

    for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_box
      logic [9:0] tlx, tly, brx, bry;
      logic       ordered, on_horiz, on_vert;
      assign tlx = box_tlx[10*gi +: 10];
      assign tly = box_tly[10*gi +: 10];
      assign brx = box_brx[10*gi +: 10];
      assign bry = box_bry[10*gi +: 10];
      // Inverted corners would otherwise still light the tlx/brx column, so gate explicitly.
      assign ordered  = (tlx <= brx) && (tly <= bry);
      assign on_horiz = (DrawX >= tlx) && (DrawX <= brx) && ((DrawY == tly) || (DrawY == bry));
      assign on_vert  = (DrawY >= tly) && (DrawY <= bry) && ((DrawX == tlx) || (DrawX == brx));
      assign box_hit[gi] = box_en[gi] && ordered && (on_horiz || on_vert);
    end
  endgenerate

  logic                 s1_valid_reg;
  logic [9:0]           s1_x_reg, s1_y_reg;
  logic [CW-1:0]        s1_r_reg, s1_g_reg, s1_b_reg;
  logic                 s1_cursor_reg, s1_mark_reg, s1_trace_reg, s1_thr_reg, s1_blend_reg;
  logic [NUM_BOXES-1:0] s1_box_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_reg  <= 1'b0;
      s1_x_reg      <= '0;
      s1_y_reg      <= '0;
      s1_r_reg      <= '0;
      s1_g_reg      <= '0;
      s1_b_reg      <= '0;
      s1_cursor_reg <= 1'b0;
      s1_mark_reg   <= 1'b0;
      s1_trace_reg  <= 1'b0;
      s1_thr_reg    <= 1'b0;
      s1_blend_reg  <= 1'b0;
      s1_box_reg    <= '0;
    end else begin
      s1_valid_reg  <= pix_valid;
      s1_x_reg      <= DrawX;
      s1_y_reg      <= DrawY;
      s1_r_reg      <= iRed;
      s1_g_reg      <= iGreen;
      s1_b_reg      <= iBlue;
      // cursor_vis is the pre-update value, so a frame_start pixel sees the old state.
      s1_cursor_reg <= is_ball && SHOW_BALL && cursor_vis_reg;
      s1_mark_reg   <= SHOW_BOX && (|mark_hit);
      s1_trace_reg  <= SHOW_BOX && traced;
      s1_thr_reg    <= SHOW_BOX && ABOVE_T;
      s1_blend_reg  <= blend_mode;
      s1_box_reg    <= SHOW_BOX ? box_hit : '0;
    end
  end

  // ---------------- stage 2 priority select ----------------
  function automatic logic [3*CW-1:0] box_colour(input int idx);
    case (idx % 3)
      0:       box_colour = {ZERO, FS, ZERO};
      1:       box_colour = {ZERO, FS, FS};
      default: box_colour = {FS, ZERO, FS};
    endcase
  endfunction

  logic [3*CW-1:0] box_rgb;
  logic [CW-1:0]   r_next, g_next, b_next;

  always_comb begin
    box_rgb = '0;
    for (int i = NUM_BOXES - 1; i >= 0; i--) begin
      if (s1_box_reg[i]) box_rgb = box_colour(i);
    end

    r_next = s1_r_reg;
    g_next = s1_g_reg;
    b_next = s1_b_reg;
    if (!s1_valid_reg) begin
      r_next = ZERO;
      g_next = ZERO;
      b_next = ZERO;
    end else if (s1_cursor_reg) begin
      r_next = FS;
      g_next = FS;
      b_next = FS;
    end else if (s1_mark_reg) begin
      r_next = FS;
      g_next = ZERO;
      b_next = ZERO;
    end else if (s1_trace_reg) begin
      r_next = FS;
      g_next = FS;
      b_next = TRACE_BLUE;
    end else if (s1_thr_reg) begin
      if (s1_blend_reg) begin
        r_next = s1_r_reg >> 1;
        g_next = s1_g_reg >> 1;
        b_next = (s1_b_reg >> 1) + (FS >> 1);
      end else begin
        r_next = ZERO;
        g_next = ZERO;
        b_next = FS;
      end
    end else if (|s1_box_reg) begin
      {r_next, g_next, b_next} = box_rgb;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      VGA_R     <= r_next;
      VGA_G     <= g_next;
      VGA_B     <= b_next;
      out_valid <= s1_valid_reg;
      out_x     <= s1_x_reg;
      out_y     <= s1_y_reg;
    end
  end

endmodule

// File: tb/tb_overlay_compositor.sv
// Directed bench for overlay_compositor: reset, latency, priority, blend, boxes, blink, bubbles.
module tb_overlay_compositor;

  localparam int CW = 10;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          pix_valid, frame_start;
  logic [9:0]    DrawX, DrawY;
  logic [CW-1:0] iRed, iGreen, iBlue;
  logic          is_ball, SHOW_BALL, SHOW_BOX, traced, ABOVE_T, blend_mode;
  logic [1:0]    box_en;
  logic [19:0]   box_tlx, box_tly, box_brx, box_bry, mark_x, mark_y;
  logic [CW-1:0] VGA_R, VGA_G, VGA_B;
  logic          out_valid;
  logic [9:0]    out_x, out_y;

  int passed = 0;
  int total  = 0;

  overlay_compositor #(
    .CW(CW), .NUM_BOXES(2), .NUM_MARKS(2), .BLINK_FRAMES(2), .TRACE_BLUE(10'h032)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .is_ball(is_ball), .SHOW_BALL(SHOW_BALL), .SHOW_BOX(SHOW_BOX), .traced(traced),
    .ABOVE_T(ABOVE_T), .blend_mode(blend_mode), .box_en(box_en),
    .box_tlx(box_tlx), .box_tly(box_tly), .box_brx(box_brx), .box_bry(box_bry),
    .mark_x(mark_x), .mark_y(mark_y),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic set_pix(input logic [9:0] x, input logic [9:0] y,
                         input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b);
    DrawX = x; DrawY = y; iRed = r; iGreen = g; iBlue = b;
  endtask

  // Present the current inputs as one valid pixel, then check the output two edges later.
  task automatic run_pix(input string tag, input logic [CW-1:0] er,
                         input logic [CW-1:0] eg, input logic [CW-1:0] eb);
    logic [9:0] x;
    x = DrawX;
    pix_valid = 1'b1;
    @(posedge Clk); #1;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    @(posedge Clk); #1;
    chk({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, ".rgb"}, 64'({VGA_R, VGA_G, VGA_B}), 64'({er, eg, eb}));
    $display("pixel %s x=%0d -> valid=%0b rgb=(%0h,%0h,%0h)", tag, x, out_valid, VGA_R, VGA_G, VGA_B);
  endtask

  initial begin
    Reset_n = 1'b0; pix_valid = 1'b0; frame_start = 1'b0;
    set_pix(10'd0, 10'd0, '0, '0, '0);
    is_ball = 0; SHOW_BALL = 0; SHOW_BOX = 0; traced = 0; ABOVE_T = 0; blend_mode = 0;
    box_en = 2'b00;
    box_tlx = {10'd15, 10'd10}; box_tly = {10'd15, 10'd10};
    box_brx = {10'd30, 10'd20}; box_bry = {10'd30, 10'd20};
    mark_x  = {10'd50, 10'd40}; mark_y  = {10'd60, 10'd45};
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // T1: reset in the middle of a valid stream
    set_pix(10'd7, 10'd1, 10'd7, 10'd8, 10'd9);
    pix_valid = 1'b1;
    repeat (3) @(posedge Clk);
    #1 chk("stream.valid", 64'(out_valid), 64'(1'b1));
    #2 Reset_n = 1'b0;
    #1;
    chk("reset.valid", 64'(out_valid), 64'(1'b0));
    chk("reset.rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'(0));
    chk("reset.x", 64'(out_x), 64'(0));
    pix_valid = 1'b0;
    @(posedge Clk); #1 Reset_n = 1'b1;
    @(posedge Clk); #1;
    chk("flush.valid", 64'(out_valid), 64'(1'b0));

    set_pix(10'd5, 10'd0, 10'd3, 10'd4, 10'd5);
    pix_valid = 1'b1;
    @(posedge Clk); #1;
    pix_valid = 1'b0;
    chk("lat.early_valid", 64'(out_valid), 64'(1'b0));
    @(posedge Clk); #1;
    chk("lat.valid", 64'(out_valid), 64'(1'b1));
    chk("lat.x", 64'(out_x), 64'(5));
    chk("lat.rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'({10'd3, 10'd4, 10'd5}));
    $display("pixel lat x=%0d -> rgb=(%0h,%0h,%0h)", out_x, VGA_R, VGA_G, VGA_B);

    // T2: priority on marker 1 pixel
    is_ball = 1; SHOW_BALL = 1; SHOW_BOX = 1; traced = 1; ABOVE_T = 1;
    set_pix(10'd50, 10'd60, 10'd1, 10'd2, 10'd3);
    run_pix("prio.cursor", 10'h3FF, 10'h3FF, 10'h3FF);
    is_ball = 0;
    run_pix("prio.marker", 10'h3FF, 10'h000, 10'h000);
    set_pix(10'd40, 10'd45, 10'd1, 10'd2, 10'd3);
    run_pix("prio.marker0", 10'h3FF, 10'h000, 10'h000);
    set_pix(10'd51, 10'd60, 10'd1, 10'd2, 10'd3);
    run_pix("prio.trace", 10'h3FF, 10'h3FF, 10'h032);
    SHOW_BOX = 0;
    run_pix("prio.gated", 10'd1, 10'd2, 10'd3);
    SHOW_BOX = 1;

    // T3: threshold opaque and blend
    traced = 0;
    set_pix(10'd51, 10'd60, 10'h200, 10'h100, 10'h3FF);
    run_pix("thr.opaque", 10'h000, 10'h000, 10'h3FF);
    blend_mode = 1;
    run_pix("thr.blend", 10'h100, 10'h080, 10'h3FE);
    ABOVE_T = 0; blend_mode = 0;

    // T4: bounding boxes
    box_en = 2'b11;
    set_pix(10'd20, 10'd15, 10'd1, 10'd2, 10'd3);
    run_pix("box.overlap", 10'h000, 10'h3FF, 10'h000);
    set_pix(10'd30, 10'd25, 10'd1, 10'd2, 10'd3);
    run_pix("box.cyan", 10'h000, 10'h3FF, 10'h3FF);
    set_pix(10'd12, 10'd25, 10'd1, 10'd2, 10'd3);
    run_pix("box.outside", 10'd1, 10'd2, 10'd3);
    box_en = 2'b10;
    set_pix(10'd20, 10'd15, 10'd1, 10'd2, 10'd3);
    run_pix("box.en0_off", 10'h000, 10'h3FF, 10'h3FF);
    box_en = 2'b11;
    box_tlx = {10'd15, 10'd25};
    set_pix(10'd25, 10'd12, 10'd1, 10'd2, 10'd3);
    run_pix("box.inverted", 10'd1, 10'd2, 10'd3);
    box_tlx = {10'd15, 10'd10};
    SHOW_BOX = 0;

    // T5: blink, half-period 2 frames; frame 0 is the one running since reset
    is_ball = 1; SHOW_BALL = 1;
    set_pix(10'd100, 10'd100, 10'd7, 10'd8, 10'd9);
    run_pix("blink.f0", 10'h3FF, 10'h3FF, 10'h3FF);
    for (int k = 1; k <= 5; k++) begin
      logic vis_old, vis_new;
      vis_old = (((k - 1) / 2) % 2) == 0;
      vis_new = ((k / 2) % 2) == 0;
      frame_start = 1'b1;
      if (vis_old) run_pix($sformatf("blink.edge%0d", k), 10'h3FF, 10'h3FF, 10'h3FF);
      else         run_pix($sformatf("blink.edge%0d", k), 10'd7, 10'd8, 10'd9);
      if (vis_new) run_pix($sformatf("blink.f%0d", k), 10'h3FF, 10'h3FF, 10'h3FF);
      else         run_pix($sformatf("blink.f%0d", k), 10'd7, 10'd8, 10'd9);
    end
    is_ball = 0; SHOW_BALL = 0;

    // T6: bubble pattern 1,0,1
    set_pix(10'd1, 10'd2, 10'd11, 10'd12, 10'd13);
    pix_valid = 1'b1;
    @(posedge Clk); #1;
    set_pix(10'd2, 10'd2, 10'd21, 10'd22, 10'd23);
    pix_valid = 1'b0;
    @(posedge Clk); #1;
    chk("bub.v0", 64'(out_valid), 64'(1'b1));
    chk("bub.rgb0", 64'({VGA_R, VGA_G, VGA_B}), 64'({10'd11, 10'd12, 10'd13}));
    set_pix(10'd3, 10'd2, 10'd31, 10'd32, 10'd33);
    pix_valid = 1'b1;
    @(posedge Clk); #1;
    chk("bub.v1", 64'(out_valid), 64'(1'b0));
    chk("bub.rgb1", 64'({VGA_R, VGA_G, VGA_B}), 64'(0));
    pix_valid = 1'b0;
    @(posedge Clk); #1;
    chk("bub.v2", 64'(out_valid), 64'(1'b1));
    chk("bub.rgb2", 64'({VGA_R, VGA_G, VGA_B}), 64'({10'd31, 10'd32, 10'd33}));
    chk("bub.x2", 64'(out_x), 64'(3));
    $display("bubbles done x=%0d valid=%0b", out_x, out_valid);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
